// File: rtl/word_unpacker_pkg.sv
// Shared definitions for the wide-word to serial-sample unpacker:
// default geometry, the FSM state type and a lane-slice helper.
package porcom_pkg;

  localparam int unsigned SAMPLE_W = 21;
  localparam int unsigned LANES    = 8;
  localparam int unsigned WIDTH    = LANES * SAMPLE_W;
  localparam int unsigned LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Extract lane idx of a default-geometry packed word, sign preserved.
  function automatic logic signed [SAMPLE_W-1:0] get_lane(
    input logic [WIDTH-1:0] word,
    input int unsigned      idx
  );
    return $signed(word[idx*SAMPLE_W +: SAMPLE_W]);
  endfunction

endpackage

// File: rtl/word_unpacker_if.sv
// Word-in / sample-out handshake bundle for word_unpacker.
// slave is the unpacker's view; master is the surrounding datapath's view.
interface word_unpacker_if #(
  parameter  int unsigned LANES    = porcom_pkg::LANES,
  parameter  int unsigned SAMPLE_W = porcom_pkg::SAMPLE_W,
  localparam int unsigned WIDTH    = LANES * SAMPLE_W,
  localparam int unsigned LANE_W   = (LANES > 1) ? $clog2(LANES) : 1
);

  logic                       i_valid;
  logic                       o_ready;
  logic [WIDTH-1:0]           i_data;
  logic                       o_valid;
  logic                       i_ready;
  logic signed [SAMPLE_W-1:0] o_data;
  logic [LANE_W-1:0]          o_lane;
  logic                       o_last;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_lane, o_last
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_lane, o_last
  );

endinterface

// File: rtl/word_unpacker_lane_mux.sv
// Combinational lane selector: picks sample i_idx out of a packed word.
// Out-of-range indices yield zero.
module lane_mux #(
  parameter  int unsigned LANES    = porcom_pkg::LANES,
  parameter  int unsigned SAMPLE_W = porcom_pkg::SAMPLE_W,
  localparam int unsigned WIDTH    = LANES * SAMPLE_W,
  localparam int unsigned LANE_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [WIDTH-1:0]           i_word,
  input  logic [LANE_W-1:0]          i_idx,
  output logic signed [SAMPLE_W-1:0] o_sample
);

  always_comb begin
    o_sample = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (i_idx == LANE_W'(k)) begin
        o_sample = $signed(i_word[k*SAMPLE_W +: SAMPLE_W]);
      end
    end
  end

endmodule

// File: rtl/word_unpacker.sv
// Accepts one packed word of LANES signed samples and emits them one per
// cycle, lane 0 first, over a valid/ready handshake with backpressure.
module word_unpacker #(
  parameter  int unsigned LANES    = porcom_pkg::LANES,
  parameter  int unsigned SAMPLE_W = porcom_pkg::SAMPLE_W,
  localparam int unsigned WIDTH    = LANES * SAMPLE_W,
  localparam int unsigned LANE_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [SAMPLE_W-1:0] o_data,
  output logic [LANE_W-1:0]          o_lane,
  output logic                       o_last
);

  import porcom_pkg::*;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t                     r_state;
  state_t                     w_state_n;
  logic [WIDTH-1:0]           r_hold;
  logic [WIDTH-1:0]           w_hold_n;
  logic [LANE_W-1:0]          r_lane;
  logic [LANE_W-1:0]          w_lane_n;
  logic                       r_valid;
  logic                       r_last;
  logic signed [SAMPLE_W-1:0] r_data;
  logic signed [SAMPLE_W-1:0] w_sample;
  logic                       w_at_last;
  logic                       w_in_xfer;
  logic                       w_out_xfer;

  assign w_at_last = (r_lane == LAST_LANE);

  // i_ready feeds o_ready combinationally so a new word can load on the
  // same edge the final lane leaves, giving gap-free word succession.
  assign o_ready    = (r_state == IDLE) ||
                      ((r_state == SHIFT) && w_at_last && i_ready);
  assign w_in_xfer  = i_valid && o_ready;
  assign w_out_xfer = r_valid && i_ready;

  always_comb begin
    w_state_n = r_state;
    w_hold_n  = r_hold;
    w_lane_n  = r_lane;
    unique case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          w_hold_n  = i_data;
          w_lane_n  = '0;
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (w_out_xfer) begin
          if (!w_at_last) begin
            w_lane_n = r_lane + 1'b1;
          end else if (w_in_xfer) begin
            w_hold_n = i_data;
            w_lane_n = '0;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Selecting on next-state values lets o_data be a plain register that
  // already holds the sample the following cycle presents.
  lane_mux #(
    .LANES    (LANES),
    .SAMPLE_W (SAMPLE_W)
  ) u_lane_mux (
    .i_word   (w_hold_n),
    .i_idx    (w_lane_n),
    .o_sample (w_sample)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_lane  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_hold  <= w_hold_n;
      r_lane  <= w_lane_n;
      r_valid <= (w_state_n == SHIFT);
      r_data  <= w_sample;
      r_last  <= (w_state_n == SHIFT) && (w_lane_n == LAST_LANE);
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_lane  = r_lane;
  assign o_last  = r_last;

endmodule

// File: tb/tb_word_unpacker.sv
// Randomised and directed bench for word_unpacker: an 8x21 instance checked
// against a sample-queue model, plus a 1x168 instance for single-lane words.
module tb_word_unpacker;

  localparam int unsigned L  = 8;
  localparam int unsigned SW = 21;
  localparam int unsigned W  = L * SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_unpacker_if #(.LANES(L), .SAMPLE_W(SW)) bus ();

  word_unpacker #(.LANES(L), .SAMPLE_W(SW)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_valid (bus.i_valid),
    .o_ready (bus.o_ready),
    .i_data  (bus.i_data),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready),
    .o_data  (bus.o_data),
    .o_lane  (bus.o_lane),
    .o_last  (bus.o_last)
  );

  logic         d1_ivalid, d1_oready, d1_ovalid, d1_iready, d1_olast;
  logic [167:0] d1_idata, d1_odata;
  logic [0:0]   d1_olane;

  word_unpacker #(.LANES(1), .SAMPLE_W(168)) dut1 (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_valid (d1_ivalid),
    .o_ready (d1_oready),
    .i_data  (d1_idata),
    .o_valid (d1_ovalid),
    .i_ready (d1_iready),
    .o_data  (d1_odata),
    .o_lane  (d1_olane),
    .o_last  (d1_olast)
  );

  typedef struct {
    logic signed [SW-1:0] d;
    int unsigned          lane;
  } beat_t;

  typedef int lanes_t [L];

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [167:0] got, input logic [167:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input lanes_t v);
    logic [W-1:0] w;
    logic [31:0]  t;
    w = '0;
    for (int k = 0; k < L; k++) begin
      t = v[k];
      w[k*SW +: SW] = t[SW-1:0];
    end
    return w;
  endfunction

  function automatic logic [167:0] rand168();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[167:0];
  endfunction

  // Model: queue of samples still owed downstream. Only one word is ever in
  // flight, so ready means "nothing owed, or only the final sample owed and
  // it leaves this cycle".
  task automatic step(output bit acc);
    bit exp_v, exp_r;
    #1;
    exp_v = (q.size() != 0);
    exp_r = (q.size() == 0) || (q.size() == 1 && bus.i_ready);
    chk("o_valid", bus.o_valid, exp_v);
    chk("o_ready", bus.o_ready, exp_r);
    if (exp_v) begin
      chk("o_data", bus.o_data, q[0].d);
      chk("o_lane", bus.o_lane, q[0].lane);
      chk("o_last", bus.o_last, q[0].lane == L - 1);
    end
    acc = bus.i_valid && exp_r;
    if (exp_v && bus.i_ready) void'(q.pop_front());
    if (acc) begin
      for (int k = 0; k < L; k++) begin
        beat_t b;
        b.d    = $signed(bus.i_data[k*SW +: SW]);
        b.lane = k;
        q.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] w);
    bit acc = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = w;
    for (int t = 0; t < 40; t++) begin
      step(acc);
      if (acc) break;
    end
    chk("accept_timeout", acc, 1'b1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bit acc;
    bus.i_ready = 1'b1;
    for (int t = 0; t < n; t++) step(acc);
  endtask

  initial begin
    lanes_t       va, vb, vx;
    logic [W-1:0] wa, wb;
    logic [3:0]   pat;
    logic [167:0] prev;
    bit           acc, have_prev;

    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = '0;
    d1_ivalid   = 1'b0;
    d1_iready   = 1'b0;
    d1_idata    = '0;

    #1;
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_o_data",  bus.o_data,  '0);
    chk("rst_o_lane",  bus.o_lane,  '0);
    chk("rst_o_last",  bus.o_last,  1'b0);
    chk("rst1_o_valid", d1_ovalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < L; k++) begin
      va[k] = k + 1;
      vb[k] = -(k + 1);
    end
    wa = pack(va);
    wb = pack(vb);

    // Single word then idle.
    bus.i_ready = 1'b1;
    send(wa);
    drain(10);

    // Back-to-back words with no gap.
    send(wa);
    send(wb);
    drain(18);

    // Backpressure pattern 1,0,0,1 repeating.
    pat = 4'b1001;
    bus.i_valid = 1'b1;
    bus.i_data  = wa;
    for (int i = 0; i < 40; i++) begin
      bus.i_ready = pat[i % 4];
      step(acc);
      if (acc) bus.i_valid = 1'b0;
    end
    drain(10);

    // Signed extremes.
    vx[0] = -1048576; vx[1] = 1048575; vx[2] = 0;       vx[3] = -1;
    vx[4] = 1;        vx[5] = -2;      vx[6] = 349525;  vx[7] = -349526;
    send(pack(vx));
    drain(10);

    // Random traffic with random backpressure; upstream holds until taken.
    for (int i = 0; i < 400; i++) begin
      if (!bus.i_valid && $urandom_range(0, 2) != 0) begin
        bus.i_valid = 1'b1;
        bus.i_data  = rand168();
      end
      bus.i_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) bus.i_valid = 1'b0;
    end
    bus.i_valid = 1'b0;
    drain(20);

    // Reset in the middle of a word.
    send(wa);
    for (int i = 0; i < 4; i++) step(acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", bus.o_valid, 1'b0);
    chk("midrst_o_data",  bus.o_data,  '0);
    chk("midrst_o_lane",  bus.o_lane,  '0);
    chk("midrst_o_last",  bus.o_last,  1'b0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(wb);
    drain(12);

    // Single-lane build: one beat per word, o_last on every beat.
    d1_iready = 1'b1;
    have_prev = 1'b0;
    prev      = '0;
    for (int i = 0; i < 12; i++) begin
      d1_ivalid = 1'b1;
      d1_idata  = rand168();
      #1;
      chk("l1_o_ready", d1_oready, 1'b1);
      chk("l1_o_valid", d1_ovalid, have_prev);
      if (have_prev) begin
        chk("l1_o_data", d1_odata, prev);
        chk("l1_o_last", d1_olast, 1'b1);
        chk("l1_o_lane", d1_olane, 1'b0);
      end
      prev      = d1_idata;
      have_prev = 1'b1;
      @(negedge clk);
    end
    d1_ivalid = 1'b0;
    #1;
    chk("l1_tail_valid", d1_ovalid, 1'b1);
    chk("l1_tail_data",  d1_odata,  prev);
    @(negedge clk);
    #1;
    chk("l1_idle_valid", d1_ovalid, 1'b0);
    chk("l1_idle_ready", d1_oready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_unpacker.md
Name: word_unpacker

Overview:
- Reader-side counterpart of the valid-gated wide-word pipeline. It accepts one WIDTH-bit word made of LANES signed samples, then emits the samples one per cycle, lane 0 first.
- Sits at the output end of the parallel datapath and feeds serial consumers (slicer, logger, serial TX) over a valid/ready handshake with backpressure.
- Sustains full throughput: one sample per cycle with no bubble between consecutive words.

Parameters:
- LANES, 8, number of samples per input word (>=1).
- SAMPLE_W, 21, bits per signed sample.
- WIDTH, LANES*SAMPLE_W (168), input word width. Derived; not overridden independently.
- LANE_W, $clog2(LANES) with minimum 1, width of the lane index.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  block can accept a word this cycle.
- i_data  in  WIDTH  signed packed word; lane k = i_data[k*SAMPLE_W +: SAMPLE_W].
- o_valid  out  1  o_data holds a valid sample.
- i_ready  in  1  downstream accepts the sample.
- o_data  out  SAMPLE_W  signed sample.
- o_lane  out  LANE_W  index of the lane currently presented.
- o_last  out  1  high when o_lane == LANES-1 and o_valid.

Behaviour:
- Reset: i_reset low (async) sets state IDLE, lane counter 0, holding register 0, o_valid 0, o_data 0, o_lane 0, o_last 0. o_ready reads 1 once reset is released.
- Reset mid-word: any partial word is discarded, with no further output beats. The first word accepted after reset restarts at lane 0.
- Input transfer: occurs on a clock edge when i_valid && o_ready. Output transfer: occurs on a clock edge when o_valid && i_ready.
- State IDLE:
  - o_valid=0, o_ready=1.
  - Input transfer: latch i_data into the holding register, set lane=0, go to SHIFT.
- State SHIFT:
  - o_valid=1, o_data = hold[lane], o_lane = lane.
  - Output transfer with lane < LANES-1: lane increments.
  - Output transfer with lane == LANES-1: the word completes. If an input transfer also occurs in the same cycle, load the new word, set lane=0 and stay in SHIFT (no bubble). Otherwise go to IDLE.
- o_ready = (state==IDLE) || (state==SHIFT && lane==LANES-1 && i_ready). This is a combinational path from i_ready to o_ready, and it is intentional.
- Latency: a word accepted at edge N presents lane 0 in the cycle after edge N. A word takes LANES output transfers to drain.
- Backpressure: while i_ready=0, o_data, o_lane and o_valid hold stable. The holding register never changes while a word is in flight.
- i_valid while o_ready=0: ignored. Upstream must hold the word until the transfer occurs.
- LANES=1: every output transfer completes a word, and o_last is high on every valid beat.
- No arithmetic: samples pass through bit-exact, sign preserved.
- The lane counter never exceeds LANES-1. No wrap occurs except via the complete/reload path.

Decomposition:
- Shared package porcom_pkg: SAMPLE_W, LANES, WIDTH (= LANES*SAMPLE_W), state enum {IDLE, SHIFT}, and a lane-slice function get_lane(word, idx).
- Sub-module lane_mux (WIDTH-bit word + index -> SAMPLE_W-bit sample, combinational) is natural. Everything else stays flat.

Test Plan:
- Single word, i_ready=1: i_data lanes = 1,2,...,8 (lane 0 = 1), one i_valid pulse -> o_data 1..8 on 8 consecutive cycles starting the cycle after acceptance; o_last only with 8; then o_valid=0 and o_ready=1.
- Back-to-back, i_ready=1: words A (lanes 1..8) and B (lanes -1..-8), i_valid held high -> 16 consecutive valid beats 1..8 then -1..-8 with no gap. o_ready is high exactly on the acceptance cycle of A and on the lane-7 beat of A.
- Backpressure: i_ready toggles 1,0,0,1,... during word A -> each sample is held while i_ready=0; output sequence is still 1..8; o_ready stays 0 until lane 7 is accepted.
- Sign/extremes: lanes = -1048576 (min 21-bit), 1048575 (max), 0, -1, ... -> bit-exact output values.
- Reset mid-word: assert i_reset low after lane 3 of word A -> o_valid=0, o_data=0 immediately (async). After release, word B emits from lane 0 and no A samples reappear.
- LANES=1, SAMPLE_W=168 build: consecutive words each yield one beat with o_last=1; throughput is 1 word per cycle under i_ready=1.
